// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one single-bit left or arithmetic-right step per clock.
// Optional macro SHIFT_SEQ_ROTATE_EN adds a ROT input that turns each step into a rotate.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SH_DIR,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic [WIDTH-1:0] D_IN,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] D_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

  // Handshake: START is a request accepted only on an IDLE edge (BUSY=0, DONE=0);
  // there is no backpressure. DONE pulses for one cycle with D_OUT valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] count;
  logic             dir;
  logic             rot_q;
  logic             rot_in;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign rot_in = ROT;
`else
  assign rot_in = 1'b0;
`endif

  assign dbg_state = state;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic right,
                                            input logic rot);
    logic fill;
    if (right) begin
      // Arithmetic shift refills with the sign bit; rotate refills with the LSB.
      fill = rot ? d[0] : d[WIDTH-1];
      return {fill, d[WIDTH-1:1]};
    end else begin
      fill = rot ? d[WIDTH-1] : 1'b0;
      return {d[WIDTH-2:0], fill};
    end
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      D_OUT <= '0;
      count <= '0;
      dir   <= 1'b0;
      rot_q <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            D_OUT <= D_IN;
            count <= SH_AMT;
            dir   <= SH_DIR;
            rot_q <= rot_in;
            if (SH_AMT != '0) begin
              state <= SHIFT;
              BUSY  <= 1'b1;
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          D_OUT <= step(D_OUT, dir, rot_q);
          count <= count - 1'b1;
          if (count == AMT_W'(1)) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          DONE  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_shift_sequencer;
  localparam int W = 32;
  localparam int A = 5;

  logic         CLK;
  logic         RST;
  logic         START;
  logic         SH_DIR;
  logic [A-1:0] SH_AMT;
  logic [W-1:0] D_IN;
  logic         ROT;
  logic [W-1:0] D_OUT;
  logic         BUSY;
  logic         DONE;
  logic [1:0]   dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .SH_DIR(SH_DIR),
    .SH_AMT(SH_AMT),
    .D_IN(D_IN),
`ifdef SHIFT_SEQ_ROTATE_EN
    .ROT(ROT),
`endif
    .D_OUT(D_OUT),
    .BUSY(BUSY),
    .DONE(DONE),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic         dir;
    int           amt;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [W-1:0] model(input logic dir, input int amt,
                                         input logic [W-1:0] d, input logic rot);
    logic [2*W-1:0]      dd;
    logic signed [W-1:0] sd;
    if (rot) begin
      dd = {d, d};
      if (!dir) begin
        dd = dd << amt;
        return dd[2*W-1:W];
      end else begin
        dd = dd >> amt;
        return dd[W-1:0];
      end
    end
    if (!dir) return d << amt;
    sd = $signed(d) >>> amt;
    return sd;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  function automatic logic rand_rot();
`ifdef SHIFT_SEQ_ROTATE_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Driver + checker for one complete operation starting from IDLE.
  task automatic run_op(input string name, input logic dir, input int amt,
                        input logic [W-1:0] din, input logic rot, input logic [W-1:0] exp);
    int done_at;
    int busy_cnt;
    logic [W-1:0] want;
    exp_q.push_back(exp);
    START  = 1'b1;
    SH_DIR = dir;
    SH_AMT = A'(amt);
    D_IN   = din;
    ROT    = rot;
    tick();
    START  = 1'b0;
    SH_DIR = 1'($urandom_range(0, 1));
    SH_AMT = A'($urandom);
    D_IN   = $urandom;
    ROT    = rand_rot();
    done_at  = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (DONE) begin
        done_at = k;
        break;
      end
      if (BUSY) busy_cnt++;
      tick();
    end
    want = exp_q.pop_front();
    check({name, " done_latency"}, W'(done_at), W'(amt));
    check({name, " busy_cycles"}, W'(busy_cnt), W'(amt));
    check({name, " result"}, D_OUT, want);
    tick();
    check({name, " done_pulse_end"}, W'(DONE), W'(0));
    check({name, " result_hold"}, D_OUT, want);
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] y;
    RST = 1'b1; START = 1'b0; SH_DIR = 1'b0; SH_AMT = '0; D_IN = '0; ROT = 1'b0;
    do_reset();
    check("reset D_OUT", D_OUT, '0);
    check("reset BUSY", W'(BUSY), W'(0));
    check("reset DONE", W'(DONE), W'(0));
    check("reset state", W'(dbg_state), W'(0));

    vecs[0] = '{1'b0, 4,  32'h0000_0003, 32'h0000_0030};
    vecs[1] = '{1'b1, 3,  32'h8000_0010, 32'hF000_0002};
    vecs[2] = '{1'b0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 31, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{1'b1, 31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 31, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[7] = '{1'b0, 1,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[8] = '{1'b1, 1,  32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{1'b0, 16, 32'h0000_ABCD, 32'hABCD_0000};
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].dir, vecs[i].amt, vecs[i].din, 1'b0, vecs[i].exp);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("rot_right", 1'b1, 4, 32'h0000_0001, 1'b1, 32'h1000_0000);
    run_op("rot_left", 1'b0, 4, 32'h8000_0001, 1'b1, 32'h0000_0018);
`endif

    // START during BUSY is ignored; START held high restarts after one IDLE cycle.
    START = 1'b1; SH_DIR = 1'b0; SH_AMT = 5'd6; D_IN = 32'h0000_0101; ROT = 1'b0;
    tick();
    START = 1'b0;
    tick();
    y = 32'h1234_5678;
    START = 1'b1; SH_DIR = 1'b1; SH_AMT = 5'd1; D_IN = y;
    done_seen = -1;
    for (int k = 1; k < 40; k++) begin
      if (DONE) begin
        done_seen = k;
        break;
      end
      tick();
    end
    check("ignore done_latency", W'(done_seen), W'(6));
    check("ignore result", D_OUT, 32'h0000_4040);
    tick();
    check("held idle_gap", W'(BUSY | DONE), W'(0));
    tick();
    check("held restart busy", W'(BUSY), W'(1));
    START = 1'b0;
    tick();
    check("held second done", W'(DONE), W'(1));
    check("held second result", D_OUT, model(1'b1, 1, y, 1'b0));
    tick();

    // Reset in the second SHIFT cycle aborts without DONE.
    START = 1'b1; SH_DIR = 1'b0; SH_AMT = 5'd8; D_IN = 32'hFFFF_0000;
    tick();
    START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort D_OUT", D_OUT, '0);
    check("abort state", W'(dbg_state), W'(0));
    check("abort BUSY", W'(BUSY), W'(0));
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (DONE) done_seen++;
      tick();
    end
    check("abort no_done", W'(done_seen), W'(0));
    run_op("after_reset", 1'b0, 2, 32'h0000_0005, 1'b0, 32'h0000_0014);

    for (int i = 0; i < 40; i++) begin
      logic         d;
      int           amt;
      logic [W-1:0] din;
      logic         r;
      d   = 1'($urandom_range(0, 1));
      amt = $urandom_range(0, 31);
      din = $urandom;
      r   = rand_rot();
      run_op($sformatf("rand%0d", i), d, amt, din, r, model(d, amt, din, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
